memory_sequencer: RTL

- Sequences the memory block (MAR/PC address registers, 2-word cells, READ/WRITE/ABSOLUTE/REL_ADD/REL_SUB/INC ops) on behalf of two requesters.
- Requester 1 is instruction fetch: a 16-bit instruction at PC (word 0 = high byte, word 1 = low byte), then PC increments.
- Requester 2 is data access: load, store, and PC jumps.
- Arbitrates between the two with a req/ack handshake and drives the memory's op, bus_selector, data_word_selector and in ports.

---
 rtl/memory_sequencer_pkg.sv | 59 +++++
 rtl/memory_sequencer_seq_arbiter.sv | 48 ++++
 rtl/memory_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_sequencer_pkg.sv
// Shared types for the memory sequencer: memory op/bus encodings, data commands, FSM states.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package memory_sequencer_pkg;

   localparam int WORD_W  = 8;
   localparam int INSTR_W = 16;

   // Operation codes understood by the memory block.
   typedef enum logic [2:0] {
      NOP      = 3'd0,
      READ     = 3'd1,
      WRITE    = 3'd2,
      ABSOLUTE = 3'd3,
      REL_ADD  = 3'd4,
      REL_SUB  = 3'd5,
      INC      = 3'd6
   } memory_op_e;

   // Which address register the memory op targets.
   typedef enum logic {
      MAR = 1'b0,
      PC  = 1'b1
   } memory_bus_selector_e;

   // Commands accepted from the data requester.
   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      STORE    = 3'd1,
      JUMP_ABS = 3'd2,
      JUMP_ADD = 3'd3,
      JUMP_SUB = 3'd4
   } data_cmd_e;

   typedef enum logic [3:0] {
      IDLE        = 4'd0,
      F_RD0_ISSUE = 4'd1,
      F_RD0_CAP   = 4'd2,
      F_RD1_ISSUE = 4'd3,
      F_RD1_CAP   = 4'd4,
      F_INC       = 4'd5,
      D_SETMAR    = 4'd6,
      D_RD_ISSUE  = 4'd7,
      D_RD_CAP    = 4'd8,
      D_WR        = 4'd9,
      D_JMP       = 4'd10,
      D_DONE      = 4'd11
   } seq_state_e;

   // Memory op that implements a PC jump command.
   function automatic memory_op_e jump_op(input data_cmd_e cmd);
      case (cmd)
         JUMP_ADD: jump_op = REL_ADD;
         JUMP_SUB: jump_op = REL_SUB;
         default:  jump_op = ABSOLUTE;
      endcase
   endfunction

endpackage

// File: rtl/memory_sequencer_seq_arbiter.sv
// Two-way arbiter (fetch vs data) with a last-grant register; optional round-robin.
// Latency: combinational grant while enabled; last-grant register updates on the grant edge.
// Backpressure: grants only while i_enable is high; requesters hold req until granted.
// Ports: i_clock/i_reset (async, active-high), i_enable (sequencer idle),
//        i_fetch_req/i_data_req requests, o_grant_fetch/o_grant_data one-hot grants.
module seq_arbiter
#(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_enable,
   input  logic i_fetch_req,
   input  logic i_data_req,
   output logic o_grant_fetch,
   output logic o_grant_data
);

   // 1 = fetch was granted most recently. Resets to data so fetch wins the first tie.
   logic r_last_fetch;

   always_comb begin
      o_grant_fetch = 1'b0;
      o_grant_data  = 1'b0;
      if (i_enable) begin
         if (i_fetch_req && i_data_req) begin
            if (ROUND_ROBIN) begin
               o_grant_fetch = ~r_last_fetch;
               o_grant_data  = r_last_fetch;
            end else begin
               o_grant_fetch = 1'b1;
            end
         end else begin
            o_grant_fetch = i_fetch_req;
            o_grant_data  = i_data_req;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_last_fetch <= 1'b0;
      end else if (o_grant_fetch || o_grant_data) begin
         r_last_fetch <= o_grant_fetch;
      end
   end

endmodule

// File: rtl/memory_sequencer.sv
// Sequences memory ops for an instruction-fetch requester and a data requester.
// Latency: grant edge to ack cycle = fetch 5, LOAD 4, STORE 3, jump 2.
// Backpressure: req/ack handshake; a req is held until its one-cycle ack, never preempted.
// Ports: i_clock/i_reset (async, active-high); fetch: i_fetch_req, o_fetch_ack, o_instr;
//        data: i_data_req, i_data_cmd, i_data_addr, i_data_word, i_data_wdata, o_data_ack,
//        o_data_rdata; o_busy; memory side: o_mem_in, i_mem_out, o_mem_word_sel,
//        o_mem_bus_sel, o_mem_op.
module memory_sequencer
   import memory_sequencer_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_fetch_req,
   output logic               o_fetch_ack,
   output logic [INSTR_W-1:0] o_instr,
   input  logic               i_data_req,
   input  logic [2:0]         i_data_cmd,
   input  logic [WORD_W-1:0]  i_data_addr,
   input  logic               i_data_word,
   input  logic [WORD_W-1:0]  i_data_wdata,
   output logic               o_data_ack,
   output logic [WORD_W-1:0]  o_data_rdata,
   output logic               o_busy,
   output logic [WORD_W-1:0]  o_mem_in,
   input  logic [WORD_W-1:0]  i_mem_out,
   output logic               o_mem_word_sel,
   output logic               o_mem_bus_sel,
   output logic [2:0]         o_mem_op
);

   seq_state_e           r_state;
   seq_state_e           w_next;
   data_cmd_e            r_cmd;
   logic [WORD_W-1:0]    r_addr;
   logic [WORD_W-1:0]    r_wdata;
   logic                 r_word;
   logic [INSTR_W-1:0]   r_instr;
   logic [WORD_W-1:0]    r_rdata;

   logic                 w_idle;
   logic                 w_grant_fetch;
   logic                 w_grant_data;
   memory_op_e           w_op;
   memory_bus_selector_e w_bus;
   logic [WORD_W-1:0]    w_in;
   logic                 w_word;
   logic                 w_fetch_ack;
   logic                 w_data_ack;

   assign w_idle = (r_state == IDLE);

   seq_arbiter #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_arb (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_enable      (w_idle),
      .i_fetch_req   (i_fetch_req),
      .i_data_req    (i_data_req),
      .o_grant_fetch (w_grant_fetch),
      .o_grant_data  (w_grant_data)
   );

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Command operands are frozen at the grant edge so the requester's bus may
   // change freely while the transaction runs.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_cmd   <= LOAD;
         r_addr  <= '0;
         r_word  <= 1'b0;
         r_wdata <= '0;
      end else if (w_idle && w_grant_data) begin
         r_cmd   <= data_cmd_e'(i_data_cmd);
         r_addr  <= i_data_addr;
         r_word  <= i_data_word;
         r_wdata <= i_data_wdata;
      end
   end

   // The memory only drives read data during the second READ cycle, so
   // captures happen on the edge leaving each *_CAP state.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_instr <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            F_RD0_CAP: r_instr[15:8] <= i_mem_out;
            F_RD1_CAP: r_instr[7:0]  <= i_mem_out;
            D_RD_CAP:  r_rdata       <= i_mem_out;
            default:   ;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      w_op        = NOP;
      w_bus       = MAR;
      w_in        = '0;
      w_word      = 1'b0;
      w_fetch_ack = 1'b0;
      w_data_ack  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_grant_fetch) begin
               w_next = F_RD0_ISSUE;
            end else if (w_grant_data) begin
               case (data_cmd_e'(i_data_cmd))
                  LOAD, STORE:                  w_next = D_SETMAR;
                  JUMP_ABS, JUMP_ADD, JUMP_SUB: w_next = D_JMP;
                  // Undefined command codes are acknowledged without touching memory.
                  default:                      w_next = D_DONE;
               endcase
            end
         end
         F_RD0_ISSUE: begin
            w_op   = READ;
            w_bus  = PC;
            w_next = F_RD0_CAP;
         end
         F_RD0_CAP: begin
            w_op   = READ;
            w_bus  = PC;
            w_next = F_RD1_ISSUE;
         end
         F_RD1_ISSUE: begin
            w_op   = READ;
            w_bus  = PC;
            w_word = 1'b1;
            w_next = F_RD1_CAP;
         end
         F_RD1_CAP: begin
            w_op   = READ;
            w_bus  = PC;
            w_word = 1'b1;
            w_next = F_INC;
         end
         F_INC: begin
            w_op        = INC;
            w_bus       = PC;
            w_fetch_ack = 1'b1;
            w_next      = IDLE;
         end
         D_SETMAR: begin
            w_op   = ABSOLUTE;
            w_in   = r_addr;
            w_next = (r_cmd == LOAD) ? D_RD_ISSUE : D_WR;
         end
         D_RD_ISSUE: begin
            w_op   = READ;
            w_word = r_word;
            w_next = D_RD_CAP;
         end
         D_RD_CAP: begin
            w_op   = READ;
            w_word = r_word;
            w_next = D_DONE;
         end
         D_WR: begin
            w_op   = WRITE;
            w_word = r_word;
            w_in   = r_wdata;
            w_next = D_DONE;
         end
         D_JMP: begin
            w_op   = jump_op(r_cmd);
            w_bus  = PC;
            w_in   = r_addr;
            w_next = D_DONE;
         end
         D_DONE: begin
            w_data_ack = 1'b1;
            w_next     = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign o_mem_op       = w_op;
   assign o_mem_bus_sel  = w_bus;
   assign o_mem_in       = w_in;
   assign o_mem_word_sel = w_word;
   assign o_fetch_ack    = w_fetch_ack;
   assign o_data_ack     = w_data_ack;
   assign o_instr        = r_instr;
   assign o_data_rdata   = r_rdata;
   assign o_busy         = ~w_idle;

endmodule
